// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-address width, the hard-wired zero register
// and the hazard controller state encoding.
package cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use detector: the EX load's destination matches a source the ID instruction reads.
module hazard_detect
  import cpu_pkg::*;
(
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  output logic                  load_use
);

  // r0 is never really written, so a load targeting it cannot create a dependency
  assign load_use = ex_mem_read && (ex_rd_addr != REG_ZERO) &&
                    ((ex_rd_addr == id_rs) || (id_uses_rt && (ex_rd_addr == id_rt)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: memory-wait freeze with timeout,
// load-use stall, taken-branch flush, and a saturating stall-cycle counter.
module pipeline_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REG_ADDR_W-1:0] ID_rs_i,
  input  logic [REG_ADDR_W-1:0] ID_rt_i,
  input  logic                  ID_uses_rt_i,
  input  logic                  ID_branch_taken_i,
  input  logic                  EX_MemRead_i,
  input  logic [REG_ADDR_W-1:0] EX_RDaddr_i,
  input  logic                  MEM_MemRead_i,
  input  logic                  MEM_MemWrite_i,
  input  logic                  dmem_ack_i,
  output logic                  dmem_req_o,
  output logic                  pc_write_o,
  output logic                  IF_ID_write_o,
  output logic                  ID_EX_write_o,
  output logic                  EX_MEM_write_o,
  output logic                  IF_ID_flush_o,
  output logic                  ID_EX_flush_o,
  output logic                  MEM_WB_bubble_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic                  timeout_o
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  hz_state_e         state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic              timeout_q;

  logic mem_access;
  logic freeze;
  logic wait_expired;
  logic load_use;

  assign mem_access   = MEM_MemRead_i || MEM_MemWrite_i;
  assign freeze       = ((state_q == RUN) && mem_access && !dmem_ack_i) ||
                        ((state_q == MEM_WAIT) && !dmem_ack_i && (wait_cnt_q < WAIT_LAST));
  assign wait_expired = (state_q == MEM_WAIT) && !dmem_ack_i && (wait_cnt_q >= WAIT_LAST);

  hazard_detect u_hazard_detect (
    .ex_mem_read (EX_MemRead_i),
    .ex_rd_addr  (EX_RDaddr_i),
    .id_rs       (ID_rs_i),
    .id_rt       (ID_rt_i),
    .id_uses_rt  (ID_uses_rt_i),
    .load_use    (load_use)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (mem_access && !dmem_ack_i) state_d = MEM_WAIT;
      MEM_WAIT: if (dmem_ack_i || wait_expired) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  // wait_cnt only runs inside MEM_WAIT; every RUN cycle rearms it at zero
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      wait_cnt_q <= (state_q == MEM_WAIT) ? wait_cnt_q + WAIT_W'(1) : '0;
      if (!pc_write_o && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (wait_expired)
        timeout_q <= 1'b1;
    end
  end

  // Priority: reset > freeze > load-use > taken branch > normal flow
  always_comb begin
    pc_write_o      = 1'b1;
    IF_ID_write_o   = 1'b1;
    ID_EX_write_o   = 1'b1;
    EX_MEM_write_o  = 1'b1;
    IF_ID_flush_o   = 1'b0;
    ID_EX_flush_o   = 1'b0;
    MEM_WB_bubble_o = 1'b0;
    dmem_req_o      = mem_access;
    if (rst_i) begin
      pc_write_o      = 1'b0;
      IF_ID_write_o   = 1'b0;
      ID_EX_write_o   = 1'b0;
      EX_MEM_write_o  = 1'b0;
      IF_ID_flush_o   = 1'b1;
      ID_EX_flush_o   = 1'b1;
      MEM_WB_bubble_o = 1'b1;
      dmem_req_o      = 1'b0;
    end else if (freeze) begin
      pc_write_o      = 1'b0;
      IF_ID_write_o   = 1'b0;
      ID_EX_write_o   = 1'b0;
      EX_MEM_write_o  = 1'b0;
      MEM_WB_bubble_o = 1'b1;
    end else if (load_use) begin
      pc_write_o    = 1'b0;
      IF_ID_write_o = 1'b0;
      ID_EX_flush_o = 1'b1;
    end else if (ID_branch_taken_i) begin
      IF_ID_flush_o = 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed vectors push expected outputs,
// a negedge monitor pops and compares them.
module tb_pipeline_hazard_ctrl;

  // control bits: pc_w, ifid_w, idex_w, exmem_w, ifid_flush, idex_flush, memwb_bubble
  localparam logic [6:0] C_NORM = 7'b1111000;
  localparam logic [6:0] C_RST  = 7'b0000111;
  localparam logic [6:0] C_FRZ  = 7'b0000001;
  localparam logic [6:0] C_LU   = 7'b0011010;
  localparam logic [6:0] C_BR   = 7'b1111100;

  typedef struct {
    string       name;
    logic [7:0]  ctl;
    logic [31:0] cnt;
    logic        to;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [4:0]  ID_rs_i, ID_rt_i, EX_RDaddr_i;
  logic        ID_uses_rt_i, ID_branch_taken_i, EX_MemRead_i;
  logic        MEM_MemRead_i, MEM_MemWrite_i, dmem_ack_i;
  logic        dmem_req_o, pc_write_o, IF_ID_write_o, ID_EX_write_o, EX_MEM_write_o;
  logic        IF_ID_flush_o, ID_EX_flush_o, MEM_WB_bubble_o, timeout_o;
  logic [31:0] stall_cnt_o;

  exp_t sb[$];
  int   total = 0;
  int   passed = 0;

  pipeline_hazard_ctrl #(.TIMEOUT(16), .CNT_W(32)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .ID_rs_i           (ID_rs_i),
    .ID_rt_i           (ID_rt_i),
    .ID_uses_rt_i      (ID_uses_rt_i),
    .ID_branch_taken_i (ID_branch_taken_i),
    .EX_MemRead_i      (EX_MemRead_i),
    .EX_RDaddr_i       (EX_RDaddr_i),
    .MEM_MemRead_i     (MEM_MemRead_i),
    .MEM_MemWrite_i    (MEM_MemWrite_i),
    .dmem_ack_i        (dmem_ack_i),
    .dmem_req_o        (dmem_req_o),
    .pc_write_o        (pc_write_o),
    .IF_ID_write_o     (IF_ID_write_o),
    .ID_EX_write_o     (ID_EX_write_o),
    .EX_MEM_write_o    (EX_MEM_write_o),
    .IF_ID_flush_o     (IF_ID_flush_o),
    .ID_EX_flush_o     (ID_EX_flush_o),
    .MEM_WB_bubble_o   (MEM_WB_bubble_o),
    .stall_cnt_o       (stall_cnt_o),
    .timeout_o         (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input exp_t e);
    logic [7:0] act;
    act = {dmem_req_o, pc_write_o, IF_ID_write_o, ID_EX_write_o, EX_MEM_write_o,
           IF_ID_flush_o, ID_EX_flush_o, MEM_WB_bubble_o};
    total++;
    if (act === e.ctl) passed++;
    else $display("[TB] FAIL %s.ctl: got %b expected %b", e.name, act, e.ctl);
    total++;
    if (stall_cnt_o === e.cnt) passed++;
    else $display("[TB] FAIL %s.stall_cnt: got %0d expected %0d", e.name, stall_cnt_o, e.cnt);
    total++;
    if (timeout_o === e.to) passed++;
    else $display("[TB] FAIL %s.timeout: got %b expected %b", e.name, timeout_o, e.to);
  endtask

  always @(negedge clk_i) begin
    if (sb.size() > 0) checkOutput(sb.pop_front());
  end

  // drives one cycle of inputs just after the rising edge and queues the expectation
  task automatic applyStimulus(input string name, input logic rst,
                               input logic exmr, input logic [4:0] exrd,
                               input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                               input logic br, input logic mr, input logic mw, input logic ack,
                               input logic req, input logic [6:0] ctl,
                               input int cnt, input logic to);
    exp_t e;
    @(posedge clk_i);
    #1;
    rst_i = rst; EX_MemRead_i = exmr; EX_RDaddr_i = exrd;
    ID_rs_i = rs; ID_rt_i = rt; ID_uses_rt_i = uses_rt; ID_branch_taken_i = br;
    MEM_MemRead_i = mr; MEM_MemWrite_i = mw; dmem_ack_i = ack;
    e.name = name;
    e.ctl  = {req, ctl};
    e.cnt  = cnt;
    e.to   = to;
    sb.push_back(e);
  endtask

  initial begin
    rst_i = 1'b1; EX_MemRead_i = 1'b0; EX_RDaddr_i = '0; ID_rs_i = '0; ID_rt_i = '0;
    ID_uses_rt_i = 1'b0; ID_branch_taken_i = 1'b0;
    MEM_MemRead_i = 1'b0; MEM_MemWrite_i = 1'b0; dmem_ack_i = 1'b0;

    //             name          rst exmr rd  rs  rt urt br mr mw ack  req ctl    cnt to
    applyStimulus("reset0",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, C_RST,  0, 0);
    applyStimulus("reset1",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, C_RST,  0, 0);
    applyStimulus("idle",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, C_NORM, 0, 0);
    applyStimulus("loaduse_rs",  0, 1, 8, 8, 0, 0, 0, 0, 0, 0,  0, C_LU,   0, 0);
    applyStimulus("after_lu",    0, 0, 8, 8, 0, 0, 0, 0, 0, 0,  0, C_NORM, 1, 0);
    applyStimulus("zero_reg",    0, 1, 0, 0, 0, 0, 0, 0, 0, 0,  0, C_NORM, 1, 0);
    applyStimulus("rt_unused",   0, 1, 9, 3, 9, 0, 0, 0, 0, 0,  0, C_NORM, 1, 0);
    applyStimulus("loaduse_rt",  0, 1, 9, 3, 9, 1, 0, 0, 0, 0,  0, C_LU,   1, 0);
    applyStimulus("idle2",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, C_NORM, 2, 0);
    applyStimulus("memw_frz0",   0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  1, C_FRZ,  2, 0);
    applyStimulus("memw_frz1",   0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  1, C_FRZ,  3, 0);
    applyStimulus("memw_frz2",   0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  1, C_FRZ,  4, 0);
    applyStimulus("memw_ack",    0, 0, 0, 0, 0, 0, 0, 1, 0, 1,  1, C_NORM, 5, 0);
    applyStimulus("memw_done",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, C_NORM, 5, 0);
    applyStimulus("zero_wait",   0, 0, 0, 0, 0, 0, 0, 1, 0, 1,  1, C_NORM, 5, 0);
    applyStimulus("idle3",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, C_NORM, 5, 0);
    for (int i = 0; i < 16; i++)
      applyStimulus($sformatf("tmo_frz%0d", i),
                                 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  1, C_FRZ,  5 + i, 0);
    applyStimulus("tmo_release", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  1, C_NORM, 21, 0);
    applyStimulus("tmo_sticky",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, C_NORM, 21, 1);
    applyStimulus("frz_over_lu", 0, 1, 8, 8, 0, 0, 1, 1, 0, 0,  1, C_FRZ,  21, 1);
    applyStimulus("lu_over_br",  0, 1, 8, 8, 0, 0, 1, 1, 0, 1,  1, C_LU,   22, 1);
    applyStimulus("branch",      0, 0, 8, 8, 0, 0, 1, 0, 0, 0,  0, C_BR,   23, 1);
    applyStimulus("idle4",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, C_NORM, 23, 1);
    applyStimulus("abort_frz0",  0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  1, C_FRZ,  23, 1);
    applyStimulus("abort_frz1",  0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  1, C_FRZ,  24, 1);
    applyStimulus("abort_rst",   1, 0, 0, 0, 0, 0, 0, 1, 0, 0,  0, C_RST,  25, 1);
    applyStimulus("post_abort",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, C_NORM, 0, 0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk_i);
    #1;
    if (sb.size() > 0) begin
      total++;
      $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
